// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: opcodes, function codes, mnemonics and field layout.
// Imported by both the control unit and the instruction encoder/loader.
package isa_pkg;

    localparam int INSTR_W  = 16;
    localparam int FIELD_W  = 4;
    localparam int F_OP_LSB = 12;
    localparam int F_A_LSB  = 8;
    localparam int F_B_LSB  = 4;
    localparam int F_C_LSB  = 0;

    localparam logic [FIELD_W-1:0] OPC_ADD   = 4'b0000;
    localparam logic [FIELD_W-1:0] OPC_SUB   = 4'b0001;
    localparam logic [FIELD_W-1:0] OPC_NAND  = 4'b0010;
    localparam logic [FIELD_W-1:0] OPC_UNARY = 4'b0011;
    localparam logic [FIELD_W-1:0] OPC_NOR   = 4'b0100;
    localparam logic [FIELD_W-1:0] OPC_PUSH  = 4'b0110;
    localparam logic [FIELD_W-1:0] OPC_LW    = 4'b1000;
    localparam logic [FIELD_W-1:0] OPC_SW    = 4'b1001;
    localparam logic [FIELD_W-1:0] OPC_JMP   = 4'b1100;
    localparam logic [FIELD_W-1:0] OPC_BEQ   = 4'b1101;
    localparam logic [FIELD_W-1:0] OPC_POP   = 4'b1110;
    localparam logic [FIELD_W-1:0] OPC_LWR   = 4'b1111;

    // Function codes carried in I[3:0] under OPC_UNARY.
    localparam logic [FIELD_W-1:0] FN_NEG = 4'b0000;
    localparam logic [FIELD_W-1:0] FN_SAR = 4'b0001;
    localparam logic [FIELD_W-1:0] FN_SHR = 4'b0010;
    localparam logic [FIELD_W-1:0] FN_SHL = 4'b0011;

    typedef enum logic [3:0] {
        MN_ADD     = 4'd0,
        MN_SUB     = 4'd1,
        MN_NAND    = 4'd2,
        MN_NOR     = 4'd3,
        MN_NEG     = 4'd4,
        MN_SAR     = 4'd5,
        MN_SHR     = 4'd6,
        MN_SHL     = 4'd7,
        MN_LW      = 4'd8,
        MN_SW      = 4'd9,
        MN_PUSH    = 4'd10,
        MN_POP     = 4'd11,
        MN_LWR     = 4'd12,
        MN_BEQ     = 4'd13,
        MN_JMP     = 4'd14,
        MN_ILLEGAL = 4'd15
    } mnem_e;

    typedef struct packed {
        mnem_e        op;
        logic [3:0]   rd;
        logic [3:0]   rs;
        logic [3:0]   rt;
        logic [11:0]  imm;
    } cmd_t;

    function automatic logic [INSTR_W-1:0] pack_word(
        input logic [FIELD_W-1:0] opc,
        input logic [FIELD_W-1:0] a,
        input logic [FIELD_W-1:0] b,
        input logic [FIELD_W-1:0] c
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[F_OP_LSB +: FIELD_W] = opc;
        w[F_A_LSB  +: FIELD_W] = a;
        w[F_B_LSB  +: FIELD_W] = b;
        w[F_C_LSB  +: FIELD_W] = c;
        return w;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational mnemonic-to-machine-word encoder; flags commands whose
// immediate does not fit the target field or whose mnemonic is undefined.
module instr_encode
    import isa_pkg::*;
(
    input  cmd_t               cmd_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               illegal_o
);

    logic [3:0] imm_hi;
    logic [3:0] imm_mid;
    logic [3:0] imm_lo;

    assign imm_hi  = cmd_i.imm[11:8];
    assign imm_mid = cmd_i.imm[7:4];
    assign imm_lo  = cmd_i.imm[3:0];

    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves them unassigned and infers a latch.
        word_o    = '0;
        illegal_o = 1'b0;
        case (cmd_i.op)
            MN_ADD:  word_o = pack_word(OPC_ADD,  cmd_i.rd, cmd_i.rs, cmd_i.rt);
            MN_SUB:  word_o = pack_word(OPC_SUB,  cmd_i.rd, cmd_i.rs, cmd_i.rt);
            MN_NAND: word_o = pack_word(OPC_NAND, cmd_i.rd, cmd_i.rs, cmd_i.rt);
            MN_NOR:  word_o = pack_word(OPC_NOR,  cmd_i.rd, cmd_i.rs, cmd_i.rt);
            MN_NEG:  word_o = pack_word(OPC_UNARY, cmd_i.rd, cmd_i.rs, FN_NEG);
            MN_SAR: begin
                word_o    = pack_word(OPC_UNARY, cmd_i.rd, imm_lo, FN_SAR);
                illegal_o = |{imm_hi, imm_mid};
            end
            MN_SHR: begin
                word_o    = pack_word(OPC_UNARY, cmd_i.rd, imm_lo, FN_SHR);
                illegal_o = |{imm_hi, imm_mid};
            end
            MN_SHL: begin
                word_o    = pack_word(OPC_UNARY, cmd_i.rd, imm_lo, FN_SHL);
                illegal_o = |{imm_hi, imm_mid};
            end
            MN_LW: begin
                word_o    = pack_word(OPC_LW, cmd_i.rd, imm_mid, imm_lo);
                illegal_o = |imm_hi;
            end
            MN_SW: begin
                word_o    = pack_word(OPC_SW, cmd_i.rt, imm_mid, imm_lo);
                illegal_o = |imm_hi;
            end
            MN_PUSH: word_o = pack_word(OPC_PUSH, cmd_i.rt, 4'h0, 4'h0);
            MN_POP:  word_o = pack_word(OPC_POP,  cmd_i.rd, 4'h0, 4'h0);
            MN_LWR:  word_o = pack_word(OPC_LWR,  cmd_i.rd, cmd_i.rs, 4'h0);
            MN_BEQ: begin
                word_o    = pack_word(OPC_BEQ, cmd_i.rs, cmd_i.rt, imm_lo);
                illegal_o = |{imm_hi, imm_mid};
            end
            MN_JMP:  word_o = pack_word(OPC_JMP, imm_hi, imm_mid, imm_lo);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded instruction words into instruction memory, one registered
// write per accepted command, with capacity/illegal-command error tracking.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int IMEM_AW = 8
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [3:0]         in_rd,
    input  logic [3:0]         in_rs,
    input  logic [3:0]         in_rt,
    input  logic [11:0]        in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [IMEM_AW:0]   count
);

    localparam int CNT_W = IMEM_AW + 1;
    localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {IMEM_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [IMEM_AW-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    cmd_t                cmd;
    logic [INSTR_W-1:0]  enc_word;
    logic                enc_illegal;
    logic                accept;
    logic                restart;
    logic                full;
    logic [CNT_W-1:0]    cnt_eff;

    assign cmd = '{op: mnem_e'(in_op), rd: in_rd, rs: in_rs, rt: in_rt, imm: in_imm};

    instr_encode u_encode (
        .cmd_i     (cmd),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign accept  = in_valid & in_ready;
    assign restart = start & (state_q != ST_LOAD);

    // A write accepted last cycle has not reached cnt_q yet, so count it here.
    assign cnt_eff = cnt_q + CNT_W'(we_q);
    assign full    = (cnt_eff == CAPACITY);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        last_d  = 1'b0;
        done_d  = we_q & last_q;

        if (we_q) begin
            ptr_d = ptr_q + IMEM_AW'(1);
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                if (accept) begin
                    if (enc_illegal || full) begin
                        state_d = ST_ERR;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = enc_word;
                        last_d  = in_last;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  ;
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            state_d = ST_LOAD;
            ptr_d   = base_addr;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples its peers' pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD);
    assign err        = (state_q == ST_ERR);
    // Masking with reset drops a write that was accepted just before reset.
    assign imem_we    = we_q & ~reset;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign count      = cnt_q;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encodes mnemonic-level instruction commands into 16-bit machine words and writes them sequentially into instruction memory. It is the producer side of the instruction format that the control unit consumes, and it is used for boot-time program loading and for test benches. Input is a valid/ready stream of field bundles. Output is one registered write port per encoded word, plus error detection and completion status.

## Interface
- IMEM_AW, 8, instruction memory address width; the address counter wraps at 2^IMEM_AW.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a load session at base_addr; honoured only in IDLE, ERR or DONE
- base_addr  in  IMEM_AW  first write address
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready at a rising edge
- in_op  in  4  mnemonic: ADD=0 SUB=1 NAND=2 NOR=3 NEG=4 SAR=5 SHR=6 SHL=7 LW=8 SW=9 PUSH=10 POP=11 LWR=12 BEQ=13 JMP=14; 15 is illegal
- in_rd, in_rs, in_rt  in  4 each  register fields
- in_imm  in  12  immediate
- in_last  in  1  final command of the session
- imem_we  out  1  write strobe
- imem_addr  out  IMEM_AW  write address
- imem_wdata  out  16  encoded word
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse after the last word is written
- err  out  1  sticky while in ERR
- count  out  IMEM_AW+1  words written this session

## Operation
- States: IDLE, LOAD, DONE, ERR.
  - IDLE -start-> LOAD; ptr = base_addr, count = 0.
  - LOAD -accepted in_last (legal)-> DONE.
  - LOAD -illegal command-> ERR.
  - DONE lasts one cycle, then goes to IDLE.
  - ERR holds until start (restart at LOAD) or reset.
- in_ready = (state == LOAD).
- Encoding of {I[15:12], I[11:8], I[7:4], I[3:0]}:
  - ADD/SUB/NAND/NOR: {0000/0001/0010/0100, rd, rs, rt}
  - NEG: {0011, rd, rs, 0000}
  - SAR/SHR/SHL: {0011, rd, imm[3:0], 0001/0010/0011}
  - LW: {1000, rd, imm[7:0]}
  - SW: {1001, rt, imm[7:0]}
  - PUSH: {0110, rt, 8'h00}
  - POP: {1110, rd, 8'h00}
  - LWR: {1111, rd, rs, 0000}
  - BEQ: {1101, rs, rt, imm[3:0]}
  - JMP: {1100, imm[11:0]}
- Illegal command, which sends the block to ERR with no write:
  - in_op = 15
  - shift or BEQ with imm[11:4] != 0
  - LW or SW with imm[11:8] != 0
- Capacity: if count == 2^IMEM_AW when a command is accepted, the block goes to ERR and writes nothing; the pointer never overwrites base_addr.
- The pointer increments modulo 2^IMEM_AW, so it wraps from all-ones to 0.
- Reset mid-session discards the pending write. Reset values: state IDLE, all outputs 0.

## Timing
- Handshake accepted at edge N gives imem_we = 1 in cycle N+1, with imem_addr = ptr and the encoded data; ptr and count update at edge N+1.
- Throughput is one word per cycle; back-to-back acceptance is legal.
- done is high in the cycle after the last write cycle.
- imem_we is low in every other cycle.
- Errors are detected combinationally on acceptance; err is high from cycle N+1.
- start has priority over in_valid in the same cycle; the command is not accepted because in_ready is 0 outside LOAD.
- in_valid held with in_ready low must keep its fields stable; the block does not check this.

## Structure
- Shared package isa_pkg holds:
  - opcode constants (OPC_ADD…OPC_LWR)
  - shift function codes
  - the mnemonic enum
  - field bit ranges
  - the control unit and this block both import it.
- Sub-module instr_encode: purely combinational {op, rd, rs, rt, imm} -> {word, illegal}. The top level holds the FSM, the output register, the pointer and the count.

## Test plan
- start, base 0x10; ADD rd=1 rs=2 rt=3 then SHL rd=4 imm=5 with in_last -> writes 0x0123 @0x10 and 0x3453 @0x11; done pulses; count = 2.
- JMP imm=0xABC, LW rd=7 imm=0x42, BEQ rs=1 rt=2 imm=3 back to back -> 0xCABC, 0x8742, 0xD123 on consecutive cycles.
- SAR imm=0x10 -> no write; err = 1; in_ready = 0; a later start clears err and loads normally.
- base 0xFE, three commands -> addresses 0xFE, 0xFF, 0x00; with IMEM_AW = 2 and a fifth command -> ERR, no overwrite.
- reset asserted the cycle after an acceptance -> imem_we stays 0; all outputs 0; state IDLE.
- in_op = 15, and PUSH rt=9 / POP rd=9 -> ERR for 15; 0x6900 and 0xE900 for push/pop.
